// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the async FIFO read and write controllers.
package fifo_pkg;

    localparam int PTR_WIDTH = 3;
    localparam int PTR_W     = PTR_WIDTH + 1;

    // Binary to reflected Gray code.
    function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    // Reflected Gray code back to binary (prefix XOR from the MSB down).
    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Two-flop synchronizer for a Gray-coded pointer crossing clock domains.
module ptr_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q1_q;
    logic [W-1:0] q2_q;

    // First stage may go metastable; only the second stage is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1_q <= '0;
            q2_q <= '0;
        end else begin
            q1_q <= d;
            q2_q <= q1_q;
        end
    end

    assign q = q2_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer, empty flag and fill-level tracking for the async FIFO.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int PTR_WIDTH  = fifo_pkg::PTR_WIDTH
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rinc,
    input  logic [PTR_WIDTH:0] wptr,
    output logic [PTR_WIDTH:0] rptr,
    output logic [PTR_WIDTH:0] raddr,
    output logic             rempty,
    output logic [PTR_WIDTH:0] rlevel
);

    // The Gray helpers are sized by the package, so the instance must agree.
    if ((PTR_WIDTH + 1 != PTR_W) || (FIFO_DEPTH != (1 << PTR_WIDTH))) begin : g_bad_cfg
        $error("fifo_rd_ctrl: FIFO_DEPTH/PTR_WIDTH do not match fifo_pkg");
    end

    logic [PTR_W-1:0] rbin_q,   rbin_d;
    logic [PTR_W-1:0] rgray_q,  rgray_d;
    logic             rempty_q, rempty_d;
    logic [PTR_W-1:0] rlevel_q, rlevel_d;
    logic [PTR_W-1:0] wq2;
    logic [PTR_W-1:0] wbin_s;
    logic             rpop;

    ptr_sync #(.W(PTR_W)) u_wptr_sync (
        .clk (rclk),
        .rst (rrst),
        .d   (wptr),
        .q   (wq2)
    );

    // Next pointer, empty and level all derive from the post-pop pointer so a
    // pop and a newly synchronized write land in the same edge.
    always_comb begin
        rpop     = rinc & ~rempty_q;
        rbin_d   = rbin_q + PTR_W'(rpop);
        rgray_d  = bin2gray(rbin_d);
        rempty_d = (rgray_d == wq2);
        wbin_s   = gray2bin(wq2);
        rlevel_d = wbin_s - rbin_d;
    end

    // Read-domain state; empty out of reset so nothing is popped early.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin_q   <= '0;
            rgray_q  <= '0;
            rempty_q <= 1'b1;
            rlevel_q <= '0;
        end else begin
            rbin_q   <= rbin_d;
            rgray_q  <= rgray_d;
            rempty_q <= rempty_d;
            rlevel_q <= rlevel_d;
        end
    end

    assign raddr  = rbin_q;
    assign rptr   = rgray_q;
    assign rempty = rempty_q;
    assign rlevel = rlevel_q;

endmodule
